// File: rtl/input_check.sv
// ----------------------------------------------------------------------------
// input_check
// Player-input stage. Once a round's colours have been shown, this block
// captures the player's button presses. Each press is synchronised, debounced
// and checked against the latched colour sequence. The round ends with a
// one-cycle complete_check pulse or a one-cycle fail_check pulse.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n_check    in   1   asynchronous active-low reset
//   en_check       in   1   high = run a round, low = abort to IDLE
//   seq_in_check   in  32   16 colours, 2 bits each, colour k = [2k+1:2k]
//   round_ctr      in   4   N => player must enter N+1 colours
//   btn_in         in   4   raw asynchronous buttons, btn_in[c] = colour c
//   press_colour   out  2   colour of the last accepted press
//   press_valid    out  1   1-cycle pulse per accepted press
//   complete_check out  1   1-cycle pulse: all colours entered correctly
//   fail_check     out  1   1-cycle pulse: wrong colour or timeout
//
// Configuration
//   INPUT_CHECK_TIMEOUT_EN  defined: a press must be accepted within
//                           TIMEOUT_CYCLES or the round fails.
//                           undefined: no timer, wait indefinitely.
// ----------------------------------------------------------------------------
module input_check #(
    parameter int unsigned DEBOUNCE_CYCLES = 4_000,
    parameter int unsigned TIMEOUT_CYCLES  = 30_000_000
) (
    input  logic        clk,
    input  logic        rst_n_check,
    input  logic        en_check,
    input  logic [31:0] seq_in_check,
    input  logic [3:0]  round_ctr,
    input  logic [3:0]  btn_in,
    output logic [1:0]  press_colour,
    output logic        press_valid,
    output logic        complete_check,
    output logic        fail_check
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WAIT_PRESS   = 3'd1;
    localparam logic [2:0] S_DEBOUNCE     = 3'd2;
    localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
    localparam logic [2:0] S_PASS         = 3'd4;
    localparam logic [2:0] S_FAIL         = 3'd5;

    logic [3:0]       btn_s1, btn_s2;
    logic [2:0]       state_q, state_n;
    logic [3:0]       pos_q, pos_n;
    logic [31:0]      seq_q, seq_n;
    logic [3:0]       rc_q, rc_n;
    logic [DEB_W-1:0] deb_q, deb_n;
    logic [1:0]       idx_q, idx_n;
    logic             rearm_q, rearm_n;
    logic [1:0]       colour_n;
    logic             valid_n, complete_n, fail_n;

    logic             btn_one_hot_c;
    logic [1:0]       btn_idx_c;
    logic [3:0]       cap_mask_c;
    logic [1:0]       exp_colour_c;
    logic [DEB_W-1:0] deb_inc_c;
    logic             accept_c;
    logic             timeout_hit_c;

    // Two-flop synchroniser on the raw buttons.
    always_ff @(posedge clk or negedge rst_n_check) begin
        if (!rst_n_check) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= btn_in;
            btn_s2 <= btn_s1;
        end
    end

    // One-hot decode of the synchronised buttons.
    always_comb begin
        btn_one_hot_c = 1'b1;
        btn_idx_c     = 2'd0;
        case (btn_s2)
            4'b0001: btn_idx_c = 2'd0;
            4'b0010: btn_idx_c = 2'd1;
            4'b0100: btn_idx_c = 2'd2;
            4'b1000: btn_idx_c = 2'd3;
            default: btn_one_hot_c = 1'b0;
        endcase
    end

    assign cap_mask_c   = 4'b0001 << idx_q;
    assign exp_colour_c = seq_q[{pos_q, 1'b0} +: 2];
    assign deb_inc_c    = (deb_q == DEB_MAX) ? deb_q : deb_q + DEB_W'(1);
    assign accept_c     = (state_q == S_DEBOUNCE) && (btn_s2 == cap_mask_c)
                          && (deb_q == DEB_LAST);

`ifdef INPUT_CHECK_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] timer_q;

    // Time since round start or last accepted press; frozen while releasing.
    always_ff @(posedge clk or negedge rst_n_check) begin
        if (!rst_n_check) begin
            timer_q <= '0;
        end else if (!en_check || (state_q == S_IDLE) || accept_c) begin
            timer_q <= '0;
        end else if (((state_q == S_WAIT_PRESS) || (state_q == S_DEBOUNCE))
                     && (timer_q != TIMER_MAX)) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    assign timeout_hit_c = (timer_q == TIMER_LAST);
`else
    // Timer not built: only a degenerate zero-length timeout could fire.
    assign timeout_hit_c = (TIMEOUT_CYCLES == 0);
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n_check) begin
        if (!rst_n_check) begin
            state_q        <= S_IDLE;
            pos_q          <= '0;
            seq_q          <= '0;
            rc_q           <= '0;
            deb_q          <= '0;
            idx_q          <= '0;
            rearm_q        <= 1'b0;
            press_colour   <= '0;
            press_valid    <= 1'b0;
            complete_check <= 1'b0;
            fail_check     <= 1'b0;
        end else begin
            state_q        <= state_n;
            pos_q          <= pos_n;
            seq_q          <= seq_n;
            rc_q           <= rc_n;
            deb_q          <= deb_n;
            idx_q          <= idx_n;
            rearm_q        <= rearm_n;
            press_colour   <= colour_n;
            press_valid    <= valid_n;
            complete_check <= complete_n;
            fail_check     <= fail_n;
        end
    end

    // Next-state logic; result pulses are raised on entry to PASS / FAIL.
    always_comb begin
        state_n    = state_q;
        pos_n      = pos_q;
        seq_n      = seq_q;
        rc_n       = rc_q;
        deb_n      = deb_q;
        idx_n      = idx_q;
        rearm_n    = rearm_q;
        colour_n   = press_colour;
        valid_n    = 1'b0;
        complete_n = 1'b0;
        fail_n     = 1'b0;

        if (!en_check) begin
            state_n = S_IDLE;
            pos_n   = '0;
            // rearm_q blocks a restart until en_check is seen low in IDLE.
            if (state_q == S_IDLE) begin
                rearm_n = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rearm_q) begin
                        seq_n   = seq_in_check;
                        rc_n    = round_ctr;
                        pos_n   = '0;
                        state_n = S_WAIT_PRESS;
                    end
                end
                S_WAIT_PRESS: begin
                    if (timeout_hit_c) begin
                        state_n = S_FAIL;
                        fail_n  = 1'b1;
                    end else if (btn_one_hot_c) begin
                        idx_n   = btn_idx_c;
                        deb_n   = '0;
                        state_n = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    // Acceptance outranks a same-cycle timeout.
                    if (accept_c) begin
                        colour_n = idx_q;
                        valid_n  = 1'b1;
                        if (idx_q != exp_colour_c) begin
                            state_n = S_FAIL;
                            fail_n  = 1'b1;
                        end else begin
                            deb_n   = '0;
                            state_n = S_WAIT_RELEASE;
                        end
                    end else if (timeout_hit_c) begin
                        state_n = S_FAIL;
                        fail_n  = 1'b1;
                    end else if (btn_s2 != cap_mask_c) begin
                        state_n = S_WAIT_PRESS;
                    end else begin
                        deb_n = deb_inc_c;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (btn_s2 != 4'b0000) begin
                        deb_n = '0;
                    end else if (deb_q == DEB_LAST) begin
                        // PASS check precedes the increment, so pos never wraps.
                        if (pos_q == rc_q) begin
                            state_n    = S_PASS;
                            complete_n = 1'b1;
                        end else begin
                            pos_n   = pos_q + 4'd1;
                            state_n = S_WAIT_PRESS;
                        end
                    end else begin
                        deb_n = deb_inc_c;
                    end
                end
                S_PASS, S_FAIL: begin
                    state_n = S_IDLE;
                    rearm_n = 1'b1;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_check.sv
// ----------------------------------------------------------------------------
// tb_input_check
// Self-checking bench for input_check with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
// Rounds are described as lists of button actions (mask, hold length); a
// round-level model predicts accepted presses and the round outcome.
// ----------------------------------------------------------------------------
module tb_input_check;

    localparam int DEB     = 4;
    localparam int TIMEOUT = 64;
    localparam int REL     = 10;

    logic        clk;
    logic        rst_n_check;
    logic        en_check;
    logic [31:0] seq_in_check;
    logic [3:0]  round_ctr;
    logic [3:0]  btn_in;
    logic [1:0]  press_colour;
    logic        press_valid;
    logic        complete_check;
    logic        fail_check;

    input_check #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n_check   (rst_n_check),
        .en_check      (en_check),
        .seq_in_check  (seq_in_check),
        .round_ctr     (round_ctr),
        .btn_in        (btn_in),
        .press_colour  (press_colour),
        .press_valid   (press_valid),
        .complete_check(complete_check),
        .fail_check    (fail_check)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pulse monitor, sampled on the falling edge.
    int cyc = 0;
    int pv_total = 0;
    int cc_total = 0;
    int fc_total = 0;
    int pv_cyc = 0;
    int fc_cyc = 0;
    int colours[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (press_valid === 1'b1) begin
            pv_total = pv_total + 1;
            colours.push_back(int'(press_colour));
            pv_cyc = cyc;
        end
        if (complete_check === 1'b1) cc_total = cc_total + 1;
        if (fail_check === 1'b1) begin
            fc_total = fc_total + 1;
            fc_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round description consumed by run_round.
    int it_mask[$];
    int it_hold[$];
    int model_last = 0;

    function automatic int mask_colour(input int mask);
        for (int c = 0; c < 4; c++) if (mask == (1 << c)) return c;
        return -1;
    endfunction

    task automatic run_round(input logic [31:0] seq, input logic [3:0] rc, input string tag);
        int pv0, cc0, fc0, n_acc, outcome, col, want;
        int expq[$];
        pv0 = pv_total; cc0 = cc_total; fc0 = fc_total;
        n_acc = 0; outcome = 0;
        @(negedge clk);
        seq_in_check = seq;
        round_ctr    = rc;
        en_check     = 1'b1;
        repeat (3) @(negedge clk);
        // Inputs are latched at round start; scramble them afterwards.
        seq_in_check = $urandom;
        round_ctr    = 4'($urandom_range(0, 15));
        for (int i = 0; i < it_mask.size(); i++) begin
            btn_in = 4'(it_mask[i]);
            repeat (it_hold[i]) @(negedge clk);
            btn_in = 4'b0000;
            repeat (REL) @(negedge clk);
            col = mask_colour(it_mask[i]);
            if (outcome == 0 && col >= 0 && it_hold[i] > DEB) begin
                expq.push_back(col);
                model_last = col;
                want = int'(seq[2*n_acc +: 2]);
                if (col != want) outcome = 2;
                else if (n_acc == int'(rc)) outcome = 1;
                n_acc++;
            end
            check({tag, "_presses"}, pv_total - pv0, expq.size());
        end
        repeat (20) @(negedge clk);
        check({tag, "_complete"}, cc_total - cc0, (outcome == 1) ? 1 : 0);
        check({tag, "_fail"}, fc_total - fc0, (outcome == 2) ? 1 : 0);
        for (int j = 0; j < expq.size(); j++)
            check({tag, "_colour"}, (pv0 + j < colours.size()) ? colours[pv0 + j] : -1, expq[j]);
        check({tag, "_last_colour"}, int'(press_colour), model_last);
        en_check = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push_item(input int mask, input int hold);
        it_mask.push_back(mask);
        it_hold.push_back(hold);
    endtask

    initial begin
        logic [31:0] seq;
        logic [3:0]  rc;
        int c, pv0, cc0, fc0, first;

        rst_n_check  = 1'b0;
        en_check     = 1'b0;
        seq_in_check = '0;
        round_ctr    = '0;
        btn_in       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_colour", int'(press_colour), 0);
        check("rst_valid", int'(press_valid), 0);
        check("rst_complete", int'(complete_check), 0);
        check("rst_fail", int'(fail_check), 0);
        rst_n_check = 1'b1;
        repeat (3) @(negedge clk);

        // Full correct sequence 0,1,2,3
        it_mask.delete(); it_hold.delete();
        for (int k = 0; k < 4; k++) push_item(1 << k, 10);
        run_round(32'h0000_00E4, 4'd3, "full");

        // Wrong colour with same/next-cycle fail
        it_mask.delete(); it_hold.delete();
        push_item(4'b0010, 10);
        run_round(32'h0000_0002, 4'd0, "wrong");
        check("wrong_fail_lat_ok", ((fc_cyc - pv_cyc) >= 0 && (fc_cyc - pv_cyc) <= 1) ? 1 : 0, 1);

        // Mid-round reset during DEBOUNCE (press_colour is 1 here)
        pv0 = pv_total; cc0 = cc_total; fc0 = fc_total;
        @(negedge clk);
        seq_in_check = 32'h0; round_ctr = 4'd0; en_check = 1'b1;
        repeat (3) @(negedge clk);
        btn_in = 4'b0001;
        repeat (4) @(negedge clk);
        #2 rst_n_check = 1'b0;
        #1;
        check("mrst_colour", int'(press_colour), 0);
        check("mrst_valid", int'(press_valid), 0);
        check("mrst_complete", int'(complete_check), 0);
        check("mrst_fail", int'(fail_check), 0);
        model_last = 0;
        btn_in = 4'b0000; en_check = 1'b0;
        @(negedge clk);
        rst_n_check = 1'b1;
        repeat (30) @(negedge clk);
        check("mrst_no_press", pv_total - pv0, 0);
        check("mrst_no_pulse", (cc_total - cc0) + (fc_total - fc0), 0);

        // Bounce and multi-press filtering
        it_mask.delete(); it_hold.delete();
        push_item(4'b0001, 3);
        push_item(4'b0011, 10);
        push_item(4'b0001, 10);
        run_round(32'h0000_0000, 4'd0, "filter");

        // Timeout behaviour
        fc0 = fc_total; first = 0;
        @(negedge clk);
        en_check = 1'b1;
`ifdef INPUT_CHECK_TIMEOUT_EN
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (fail_check === 1'b1 && first == 0) first = i;
        end
        check("timeout_cycle", first, TIMEOUT + 1);
        check("timeout_pulses", fc_total - fc0, 1);
`else
        repeat (1000) @(negedge clk);
        check("no_timeout", fc_total - fc0, 0);
`endif
        en_check = 1'b0;
        repeat (3) @(negedge clk);

        // Abort during WAIT_RELEASE
        pv0 = pv_total; cc0 = cc_total; fc0 = fc_total;
        @(negedge clk);
        seq_in_check = 32'h0000_0002; round_ctr = 4'd3; en_check = 1'b1;
        repeat (3) @(negedge clk);
        btn_in = 4'b0100;
        repeat (10) @(negedge clk);
        btn_in = 4'b0000;
        repeat (3) @(negedge clk);
        en_check = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_press", pv_total - pv0, 1);
        check("abort_no_pulse", (cc_total - cc0) + (fc_total - fc0), 0);
        check("abort_colour_hold", int'(press_colour), 2);
        model_last = 2;

        // Fresh round after abort starts at position 0
        it_mask.delete(); it_hold.delete();
        push_item(4'b0010, 10);
        run_round(32'h0000_0001, 4'd0, "post_abort");

        // Longest round: 16 correct colours
        seq = $urandom;
        it_mask.delete(); it_hold.delete();
        for (int k = 0; k < 16; k++) push_item(1 << int'(seq[2*k +: 2]), 9);
        run_round(seq, 4'd15, "max_round");

        // Randomised rounds with distractors and occasional wrong colours
        for (int r = 0; r < 12; r++) begin
            seq = $urandom;
            rc  = 4'($urandom_range(0, 15));
            it_mask.delete(); it_hold.delete();
            for (int k = 0; k <= int'(rc); k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        push_item(1 << $urandom_range(0, 3), $urandom_range(1, 3));
                    else
                        push_item(4'b1001, 10);
                end
                c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'(seq[2*k +: 2]);
                push_item(1 << c, 8 + $urandom_range(0, 4));
            end
            run_round(seq, rc, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
